// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and a register bank (slave).
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 8
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: ID word, N_RO status words, N_RW byte-strobed control words.
module axi_lite_regbank #(
  parameter int          ADDR_W   = 8,
  parameter int          N_RO     = 3,
  parameter int          N_RW     = 1,
  parameter logic [31:0] ID_VALUE = 32'hF00BA000,
  parameter logic [31:0] RW_RESET = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi_lite_regbank_if.slave     axi,
  input  logic [32*N_RO-1:0]    ro_in,
  output logic [32*N_RW-1:0]    rw_out,
  output logic [N_RW-1:0]       wr_pulse
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int RO_IW = (N_RO > 1) ? $clog2(N_RO) : 1;
  localparam int RW_IW = (N_RW > 1) ? $clog2(N_RW) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             aw_full_r, w_full_r, bvalid_r, rvalid_r;
  logic [IDX_W-1:0] awidx_r;
  logic [31:0]      wdata_r, rdata_r;
  logic [3:0]       wstrb_r;
  logic [1:0]       bresp_r, rresp_r;
  logic [31:0]      rw_r [N_RW];
  logic [N_RW-1:0]  wr_pulse_r;
  logic [31:0]      ro_words_s [N_RO];

  logic             awready_s, wready_s, arready_s;
  logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_hit_s;
  logic [31:0]      widx_s, ridx_s, wr_merged_s, rd_data_s;
  logic [RW_IW-1:0] wr_k_s, rd_rw_k_s;
  logic [RO_IW-1:0] rd_ro_k_s;
  logic [1:0]       rd_resp_s;
  logic             unused_addr_lsb_s;

  for (genvar k = 0; k < N_RO; k++) begin : g_ro
    assign ro_words_s[k] = ro_in[32*k +: 32];
  end
  for (genvar k = 0; k < N_RW; k++) begin : g_rw
    assign rw_out[32*k +: 32] = rw_r[k];
  end

  assign unused_addr_lsb_s = ^{axi.s_awaddr[1:0], axi.s_araddr[1:0]};

  assign awready_s = resetn & ~aw_full_r;
  assign wready_s  = resetn & ~w_full_r;
  assign arready_s = resetn & ~rvalid_r;
  assign aw_hs_s   = axi.s_awvalid & awready_s;
  assign w_hs_s    = axi.s_wvalid & wready_s;
  assign ar_hs_s   = axi.s_arvalid & arready_s;
  assign commit_s  = aw_full_r & w_full_r & (~bvalid_r | axi.s_bready);

  assign widx_s    = 32'(awidx_r);
  assign wr_hit_s  = (widx_s >= 32'(N_RO + 1)) && (widx_s <= 32'(N_RO + N_RW));
  assign wr_k_s    = RW_IW'(widx_s - 32'(N_RO + 1));
  assign ridx_s    = 32'(axi.s_araddr[ADDR_W-1:2]);

  assign axi.s_awready = awready_s;
  assign axi.s_wready  = wready_s;
  assign axi.s_arready = arready_s;
  assign axi.s_bvalid  = bvalid_r;
  assign axi.s_bresp   = bresp_r;
  assign axi.s_rvalid  = rvalid_r;
  assign axi.s_rdata   = rdata_r;
  assign axi.s_rresp   = rresp_r;
  assign wr_pulse      = wr_pulse_r;

  // Byte-strobe merge of held write data onto the targeted control word
  always_comb begin
    wr_merged_s = rw_r[wr_k_s];
    for (int b = 0; b < 4; b++) begin
      if (wstrb_r[b]) begin
        wr_merged_s[8*b +: 8] = wdata_r[8*b +: 8];
      end else begin
        wr_merged_s[8*b +: 8] = rw_r[wr_k_s][8*b +: 8];
      end
    end
  end

  // Read address decode; indices past the last RW word are unmapped, never aliased
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_SLVERR;
    rd_ro_k_s = RO_IW'(ridx_s - 32'd1);
    rd_rw_k_s = RW_IW'(ridx_s - 32'(N_RO + 1));
    if (ridx_s == 32'd0) begin
      rd_data_s = ID_VALUE;
      rd_resp_s = RESP_OKAY;
    end else if (ridx_s <= 32'(N_RO)) begin
      rd_data_s = ro_words_s[rd_ro_k_s];
      rd_resp_s = RESP_OKAY;
    end else if (ridx_s <= 32'(N_RO + N_RW)) begin
      rd_data_s = rw_r[rd_rw_k_s];
      rd_resp_s = RESP_OKAY;
    end else begin
      rd_data_s = 32'h0000_0000;
      rd_resp_s = RESP_SLVERR;
    end
  end

  // Write path: AW/W holding registers, commit into control words, B channel
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_full_r  <= 1'b0;
      w_full_r   <= 1'b0;
      awidx_r    <= {IDX_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      wstrb_r    <= 4'b0000;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {N_RW{1'b0}};
      for (int k = 0; k < N_RW; k++) begin
        rw_r[k] <= RW_RESET;
      end
    end else begin
      wr_pulse_r <= {N_RW{1'b0}};
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        awidx_r   <= axi.s_awaddr[ADDR_W-1:2];
      end else if (commit_s) begin
        aw_full_r <= 1'b0;
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        wdata_r  <= axi.s_wdata;
        wstrb_r  <= axi.s_wstrb;
      end else if (commit_s) begin
        w_full_r <= 1'b0;
      end
      // A commit on the B handshake edge keeps bvalid up with the new response
      if (commit_s) begin
        bvalid_r <= 1'b1;
        if (wr_hit_s) begin
          bresp_r            <= RESP_OKAY;
          rw_r[wr_k_s]       <= wr_merged_s;
          wr_pulse_r[wr_k_s] <= 1'b1;
        end else begin
          bresp_r <= RESP_SLVERR;
        end
      end else if (axi.s_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read path: register data/response on AR handshake, hold until R handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (axi.s_rready) begin
      rvalid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed and randomized bench for axi_lite_regbank against an address-map reference model.
module tb_axi_lite_regbank;
  localparam int N_RO = 3;
  localparam int N_RW = 1;
  localparam logic [31:0] ID_VALUE = 32'hF00BA000;

  logic clk = 1'b0;
  logic resetn;
  logic [32*N_RO-1:0] ro_in;
  logic [32*N_RW-1:0] rw_out;
  logic [N_RW-1:0] wr_pulse;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ro_m [N_RO];
  logic [31:0] rw_m [N_RW];

  axi_lite_regbank_if #(.ADDR_W(8)) bus ();

  axi_lite_regbank #(
    .ADDR_W(8), .N_RO(N_RO), .N_RW(N_RW), .ID_VALUE(ID_VALUE), .RW_RESET(32'h0)
  ) dut (
    .clk(clk), .resetn(resetn), .axi(bus),
    .ro_in(ro_in), .rw_out(rw_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ro();
    for (int k = 0; k < N_RO; k++) ro_in[32*k +: 32] = ro_m[k];
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    return m;
  endfunction

  // Reference: expected {resp, data} of a read at addr, from the address map rules
  function automatic logic [33:0] model_read(input logic [7:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    if (idx == 0) return {2'b00, ID_VALUE};
    if (idx <= N_RO) return {2'b00, ro_m[idx-1]};
    if (idx <= N_RO + N_RW) return {2'b00, rw_m[idx-N_RO-1]};
    return {2'b10, 32'h0};
  endfunction

  // Reference: apply a committed write, return {pulse, resp}
  function automatic logic [2:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    idx = int'(addr[7:2]);
    if (idx >= N_RO + 1 && idx <= N_RO + N_RW) begin
      rw_m[idx-N_RO-1] = merge(rw_m[idx-N_RO-1], data, strb);
      return 3'b1_00;
    end
    return 3'b0_10;
  endfunction

  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [2:0] exp;
    int n;
    bus.s_awvalid = 1'b1; bus.s_awaddr = addr;
    bus.s_wvalid = 1'b1;  bus.s_wdata = data; bus.s_wstrb = strb;
    chk("wr_readies", {30'd0, bus.s_awready, bus.s_wready}, 32'd3);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("wr_no_early_b", bus.s_bvalid, 32'd0);
    n = 0;
    tick();
    while (!bus.s_bvalid && n < 10) begin tick(); n++; end
    chk("wr_latency", n, 32'd0);
    exp = model_write(addr, data, strb);
    chk("wr_bresp", bus.s_bresp, exp[1:0]);
    chk("wr_rw_out", rw_out, rw_m[0]);
    chk("wr_pulse", wr_pulse, exp[2]);
    tick();
    chk("wr_b_done", bus.s_bvalid, 32'd0);
    chk("wr_pulse_one", wr_pulse, 32'd0);
  endtask

  task automatic read_txn(input logic [7:0] addr);
    logic [33:0] exp;
    exp = model_read(addr);
    bus.s_arvalid = 1'b1; bus.s_araddr = addr;
    chk("rd_arready", bus.s_arready, 32'd1);
    tick();
    bus.s_arvalid = 1'b0;
    chk("rd_rvalid", bus.s_rvalid, 32'd1);
    chk("rd_rdata", bus.s_rdata, exp[31:0]);
    chk("rd_rresp", bus.s_rresp, exp[33:32]);
    tick();
    chk("rd_r_done", bus.s_rvalid, 32'd0);
  endtask

  initial begin
    logic [31:0] d1, d2, old_v;
    logic [7:0] addr;
    int idx;
    // reset with every valid held high
    resetn = 1'b0;
    for (int k = 0; k < N_RO; k++) ro_m[k] = $urandom;
    rw_m[0] = 32'h0;
    set_ro();
    bus.s_awvalid = 1'b1; bus.s_awaddr = 8'h10;
    bus.s_wvalid = 1'b1;  bus.s_wdata = 32'hDEADBEEF; bus.s_wstrb = 4'hF;
    bus.s_arvalid = 1'b1; bus.s_araddr = 8'h10;
    bus.s_bready = 1'b0;  bus.s_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd0);
    end
    chk("rst_bvalid", bus.s_bvalid, 32'd0);
    chk("rst_rvalid", bus.s_rvalid, 32'd0);
    chk("rst_rw_out", rw_out, 32'd0);
    chk("rst_wr_pulse", wr_pulse, 32'd0);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    bus.s_bready = 1'b1;  bus.s_rready = 1'b1;
    resetn = 1'b1;
    tick();
    read_txn(8'h00);

    // aligned writes, full then partial strobe
    write_txn(8'h10, 32'h12345678, 4'b1111);
    write_txn(8'h10, 32'hAABBCCDD, 4'b0011);
    chk("strb_0011", rw_out, 32'h1234CCDD);

    // skewed: W first, AW four cycles later
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h0BADF00D; bus.s_wstrb = 4'b1111;
    tick();
    bus.s_wvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("skew_wready", bus.s_wready, 32'd0);
      chk("skew_no_b", bus.s_bvalid, 32'd0);
      tick();
    end
    bus.s_awvalid = 1'b1; bus.s_awaddr = 8'h10;
    chk("skew_wready4", bus.s_wready, 32'd0);
    tick();
    bus.s_awvalid = 1'b0;
    chk("skew_no_b4", bus.s_bvalid, 32'd0);
    tick();
    void'(model_write(8'h10, 32'h0BADF00D, 4'b1111));
    chk("skew_bvalid", bus.s_bvalid, 32'd1);
    chk("skew_rw_out", rw_out, rw_m[0]);
    tick();
    chk("skew_one_b", bus.s_bvalid, 32'd0);

    // B backpressure with a second write captured behind it
    d1 = $urandom; d2 = $urandom;
    bus.s_bready = 1'b0;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 8'h10; bus.s_wvalid = 1'b1; bus.s_wdata = d1; bus.s_wstrb = 4'hF;
    tick();
    bus.s_wdata = d2;
    tick();
    chk("bp_first_b", bus.s_bvalid, 32'd1);
    chk("bp_first_rw", rw_out, d1);
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("bp_readies", {30'd0, bus.s_awready, bus.s_wready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_b", bus.s_bvalid, 32'd1);
      chk("bp_hold_rw", rw_out, d1);
      chk("bp_no_pulse", wr_pulse, 32'd0);
      tick();
    end
    bus.s_bready = 1'b1;
    tick();
    rw_m[0] = d2;
    chk("bp_second_b", bus.s_bvalid, 32'd1);
    chk("bp_second_rw", rw_out, d2);
    chk("bp_second_pulse", wr_pulse, 32'd1);
    tick();
    chk("bp_drained", bus.s_bvalid, 32'd0);

    // read of the RW word on its commit edge returns the old value
    old_v = rw_m[0];
    d1 = $urandom;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 8'h10; bus.s_wvalid = 1'b1; bus.s_wdata = d1; bus.s_wstrb = 4'hF;
    tick();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_arvalid = 1'b1; bus.s_araddr = 8'h10;
    tick();
    bus.s_arvalid = 1'b0;
    rw_m[0] = d1;
    chk("rac_rdata_old", bus.s_rdata, old_v);
    chk("rac_rw_new", rw_out, d1);
    tick();

    // error paths
    write_txn(8'h04, 32'hFFFFFFFF, 4'hF);
    write_txn(8'hFC, 32'hFFFFFFFF, 4'hF);
    read_txn(8'hFC);
    read_txn(8'h14);

    // read backpressure with ro_in changing underneath
    ro_m[1] = 32'h55; set_ro();
    bus.s_rready = 1'b0;
    bus.s_arvalid = 1'b1; bus.s_araddr = 8'h08;
    tick();
    bus.s_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ro_m[1] = $urandom; set_ro();
      chk("rbp_rdata", bus.s_rdata, 32'h55);
      chk("rbp_arready", bus.s_arready, 32'd0);
      tick();
    end
    bus.s_rready = 1'b1;
    chk("rbp_rdata_last", bus.s_rdata, 32'h55);
    tick();
    chk("rbp_done", bus.s_rvalid, 32'd0);
    chk("rbp_arready_back", bus.s_arready, 32'd1);

    // reset drops a held W; a later AW must wait for fresh W data
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'hFFFF0000; bus.s_wstrb = 4'hF;
    tick();
    bus.s_wvalid = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rw_m[0] = 32'h0;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 8'h10;
    tick();
    bus.s_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mrst_no_commit", bus.s_bvalid, 32'd0);
      chk("mrst_rw_kept", rw_out, 32'd0);
      tick();
    end
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h00C0FFEE; bus.s_wstrb = 4'b0101;
    tick();
    bus.s_wvalid = 1'b0;
    chk("mrst_b_wait", bus.s_bvalid, 32'd0);
    tick();
    void'(model_write(8'h10, 32'h00C0FFEE, 4'b0101));
    chk("mrst_b", bus.s_bvalid, 32'd1);
    chk("mrst_rw", rw_out, rw_m[0]);
    tick();

    // randomized mix against the reference model
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N_RO; k++) ro_m[k] = $urandom;
      set_ro();
      idx = ($urandom_range(0, 9) < 5) ? (N_RO + 1) : int'($urandom_range(0, 63));
      addr = {idx[5:0], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) write_txn(addr, $urandom, 4'($urandom_range(0, 15)));
      else read_txn(addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It exposes a fixed ID word, N_RO read-only status words driven by fabric logic, and N_RW read/write control words with byte strobes and per-register write pulses. AW and W channels are accepted independently, and unmapped or illegal accesses return SLVERR. It sits between the PS AXI-Lite interconnect and PL datapath status/control.

Parameters:
ADDR_W, 8, AXI address width in bits; word index = addr[ADDR_W-1:2], addr[1:0] ignored
N_RO, 3, number of read-only status words (1..32)
N_RW, 1, number of read/write control words (1..32)
ID_VALUE, 32'hF00BA000, constant returned at word 0
RW_RESET, 32'h00000000, reset value of every RW word

Ports:
clk  in  1  clock (AXI ACLK)
resetn  in  1  synchronous active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_W  write address
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  read address
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  32  read data
s_rresp  out  2  read response: 00 OKAY, 10 SLVERR
ro_in  in  32*N_RO  status words, word k at bits [32k+31:32k]
rw_out  out  32*N_RW  control words, same packing
wr_pulse  out  N_RW  one-cycle strobe, bit k set on the cycle after rw word k is updated

Behaviour:
- Address map (word index i): i=0 ID_VALUE (RO); 1..N_RO maps to ro_in[i-1]; N_RO+1..N_RO+N_RW maps to rw word i-N_RO-1; any other index is unmapped.
- Reset (resetn=0 at a clk edge): aw_full, w_full, bvalid, rvalid, wr_pulse clear; bresp, rresp, rdata = 0; all rw words = RW_RESET. awready, wready and arready are forced 0 while resetn=0.
- Reset mid-transaction drops any held AW/W, pending B or pending R. No register update happens for a write that has not committed.
- Write channel holding registers: s_awready = ~aw_full, s_wready = ~w_full. An AW handshake latches the address and sets aw_full. A W handshake latches data and strobe and sets w_full. Either channel may arrive first, by any number of cycles, or both may arrive in the same cycle.
- Commit condition: aw_full & w_full & (~bvalid | s_bready). On the commit edge:
  - aw_full and w_full clear; bvalid sets.
  - For an RW target: bresp=OKAY; each byte with strobe=1 is updated and other bytes are kept. wr_pulse[k]=1 for exactly the next cycle, even if strobe=0000.
  - For an ID, RO or unmapped target: bresp=SLVERR and no state change.
- Minimum write latency: AW and W handshake at edge k, commit and bvalid at edge k+1.
- bvalid holds until s_bvalid & s_bready. A commit in the same edge as the B handshake keeps bvalid=1 with the new bresp (back-to-back responses). A new AW/W may be captured while B is pending; it must not commit until B is consumed or being consumed.
- Read channel: s_arready = ~rvalid. On an AR handshake, at the next edge rvalid=1 and rdata/rresp are registered. ro_in is sampled at that edge.
  - Unmapped read: rdata=0, rresp=SLVERR.
  - Mapped read: rresp=OKAY.
  - rvalid clears on s_rvalid & s_rready; the next AR is accepted the cycle after.
  - rdata is held stable while rvalid & ~s_rready.
- Read and write paths are independent. A read of an RW word in the same cycle as its commit returns the pre-commit value.
- No wrap-around: an index ≥ 1+N_RO+N_RW is unmapped, not aliased, including the top of the ADDR_W space.

Test Plan:
- Reset: assert resetn=0 for 3 cycles with valids high -> all readies 0, bvalid/rvalid 0, rw_out=0, wr_pulse=0. Read addr 0 after release -> rdata=F00BA000, rresp=00.
- Aligned write, defaults: AW+W same cycle at addr 0x10, data 0x12345678, strb 1111 -> bvalid one cycle later, bresp=00, rw_out=12345678, wr_pulse[0] high one cycle. Then write 0xAABBCCDD with strb 0011 -> rw_out=1234CCDD.
- Skewed channels: W at cycle 0, AW at cycle 4 -> wready low cycles 1-4, commit on edge 5, one bresp only.
- B backpressure: bready=0 for 6 cycles after a write, second AW+W presented -> captured (readies drop), no second rw update and no second wr_pulse until bready=1. Then the second B follows immediately.
- Error paths: write 0xFFFFFFFF to addr 0x04 and to 0xFC -> bresp=10, rw_out unchanged. Read 0xFC -> rdata=0, rresp=10.
- Read backpressure: ro_in[1]=0x55, read 0x08 with rready=0 for 4 cycles while ro_in changes -> rdata stays 0x55, arready=0 until the R handshake.
